mips_fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the MIPS core; replaces the bare PC register + IMem lookup.

---
 rtl/mips_fetch_pkg.sv | 17 +
 rtl/mips_fetch_fifo.sv | 60 ++++++
 rtl/mips_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_mips_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and defaults for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

  localparam int unsigned DEFAULT_ADDR_W   = 32;
  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] instr;
    logic [DEFAULT_ADDR_W-1:0] pc;
  } fetch_entry_t;

  function automatic int unsigned pc_step(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mips_fetch_fifo.sv
// Synchronous FIFO with registered storage; flush outranks push and pop.
// The head word is read straight out of the storage registers.
module mips_fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths (e.g. MAX_OUTST=3) correct.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (32'(count) == DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch front end: PC owner, credit-limited imem requester, prefetch FIFO.
// Optional FETCH_STATS_EN adds stat_fetched / stat_dropped counters.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned       DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [ADDR_W-1:0] dec_pc_next
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_dropped
`endif
);

  localparam int unsigned       STEP       = pc_step(DATA_W);
  localparam logic [ADDR_W-1:0] STEP_A     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STEP - 1);
  localparam int unsigned       OW         = $clog2(MAX_OUTST + 1);
  localparam int unsigned       CW         = $clog2(DEPTH + 1);
  localparam int unsigned       QW         = $clog2(MAX_OUTST + 1);
  localparam int unsigned       EW         = DATA_W + 2 * ADDR_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [OW-1:0]     outst;
  logic [OW-1:0]     drop;

  logic              req_fire;
  logic              rsp_ok;
  logic              rsp_keep;
  logic              dec_pop;

  logic [CW-1:0]     pf_count;
  logic              pf_full;
  logic              pf_empty;
  logic [EW-1:0]     pf_din;
  logic [EW-1:0]     pf_head;

  logic [ADDR_W-1:0] pcq_head;
  logic [QW-1:0]     pcq_count;
  logic              pcq_full;
  logic              pcq_empty;
  logic              unused_status;

  always_comb begin
    imem_req_valid = 1'b0;
    if (!reset && !redirect_valid && (32'(outst) < MAX_OUTST) &&
        (32'(pf_count) + 32'(outst) < DEPTH))
      imem_req_valid = 1'b1;
  end

  assign imem_req_addr = fetch_pc;
  assign req_fire      = imem_req_valid & imem_req_ready;
  // Responses with nothing outstanding are stray and ignored outright.
  assign rsp_ok        = imem_rsp_valid & (outst != '0);
  assign rsp_keep      = rsp_ok & (drop == '0) & ~redirect_valid;
  assign dec_valid     = ~pf_empty;
  assign dec_pop       = dec_valid & dec_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
    end else begin
      if (redirect_valid)
        fetch_pc <= redirect_pc & ALIGN_MASK;
      else if (req_fire)
        fetch_pc <= fetch_pc + STEP_A;
      outst <= outst + OW'(req_fire) - OW'(rsp_ok);
      // Every response still in flight after this cycle belongs to the old stream.
      if (redirect_valid)
        drop <= outst - OW'(rsp_ok);
      else if (rsp_ok && (drop != '0))
        drop <= drop - OW'(1);
    end
  end

  mips_fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTST)
  ) u_pc_q (
    .clock (clock),
    .reset (reset),
    .push  (req_fire),
    .pop   (rsp_ok & (drop == '0)),
    .flush (redirect_valid),
    .din   (fetch_pc),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_count),
    .head  (pcq_head)
  );

  // pc_next is stored rather than derived so every dec_* output reads 0 out of reset.
  assign pf_din = {imem_rsp_data, pcq_head, pcq_head + STEP_A};

  mips_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_prefetch (
    .clock (clock),
    .reset (reset),
    .push  (rsp_keep),
    .pop   (dec_pop),
    .flush (redirect_valid),
    .din   (pf_din),
    .full  (pf_full),
    .empty (pf_empty),
    .count (pf_count),
    .head  (pf_head)
  );

  assign dec_instr   = pf_head[EW-1 -: DATA_W];
  assign dec_pc      = pf_head[2*ADDR_W-1 -: ADDR_W];
  assign dec_pc_next = pf_head[ADDR_W-1:0];

  assign unused_status = ^{pcq_full, pcq_empty, pcq_count, pf_full};

`ifdef FETCH_STATS_EN
  logic rsp_drop;
  assign rsp_drop = rsp_ok & ~rsp_keep;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_dropped <= '0;
    end else begin
      stat_fetched <= stat_fetched + 32'(rsp_keep);
      stat_dropped <= stat_dropped + 32'(rsp_drop) +
                      (redirect_valid ? 32'(pf_count) : 32'd0);
    end
  end
`endif

  stray_rsp: assert property (@(posedge clock) disable iff (reset)
    !(imem_rsp_valid && (outst == '0)));

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: in-order variable-latency memory model,
// expected decode stream queued by stimulus and checked by a separate monitor.
`timescale 1ns/1ps
module tb_mips_fetch_unit;
  import mips_fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_next;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_dropped;
`endif

  mips_fetch_unit #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .DEPTH     (4),
    .MAX_OUTST (2),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pc_next    (dec_pc_next)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_dropped   (stat_dropped)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; logic [31:0] pc_next; } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          lat = 1;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_req_pc = '0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] pc_next);
    exp_t e;
    e.instr   = instr_of(pc);
    e.pc      = pc;
    e.pc_next = pc_next;
    exp_q.push_back(e);
  endtask

  // Memory model and monitor: drive response at negedge, sample just before posedge.
  always begin
    exp_t  e;
    mreq_t m;
    @(negedge clock);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #4;
    if (reset) begin
      mem_q.delete();
    end else begin
      if (redirect_valid) chk("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_req_pc);
        exp_req_pc += 32'd4;
        m.addr = imem_req_addr;
        m.due  = cyc + lat;
        mem_q.push_back(m);
      end
      if (dec_valid && dec_ready && !redirect_valid) begin
        pop_cyc.push_back(cyc);
        chk("dec_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("dec_instr", dec_instr, e.instr);
          chk("dec_pc", dec_pc, e.pc);
          chk("dec_pc_next", dec_pc_next, e.pc_next);
        end
      end
    end
  end

  // Called at a negedge; holds reset across one posedge and checks the reset image.
  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    dec_ready = 1'b0;
    exp_q.delete();
    pop_cyc.delete();
    exp_req_pc = 32'h0000_0000;
    @(posedge clock);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_dec_pc_next", dec_pc_next, 32'd0);
`ifdef FETCH_STATS_EN
    chk("rst_stat_fetched", stat_fetched, 32'd0);
    chk("rst_stat_dropped", stat_dropped, 32'd0);
`endif
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain(input int budget, input bit keep_ready);
    int n;
    n = 0;
    dec_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("drain_complete", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (!keep_ready) dec_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target, input logic [31:0] aligned);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    exp_q.delete();
    exp_req_pc     = aligned;
    @(negedge clock);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int c0;
    int nc;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    dec_ready = 1'b0;

    // Sequential fetch at one instruction per cycle.
    @(negedge clock);
    lat = 1;
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4), 32'(i * 4 + 4));
    drain(100, 1'b0);
    chk("t1_first_latency", 32'(pop_cyc.size() > 0 ? pop_cyc[0] - c0 : -1), 32'd2);
    chk("t1_rate", 32'(pop_cyc.size() >= 8 ? pop_cyc[7] - pop_cyc[0] : -1), 32'd7);

    // Decode stall: FIFO fills, credits run out, nothing lost.
    for (int i = 0; i < 10; i++) push_exp(32'(32 + i * 4), 32'(36 + i * 4));
    repeat (10) @(negedge clock);
    chk("t2_full_dec_valid", 32'(dec_valid), 32'd1);
    chk("t2_full_req_blocked", 32'(imem_req_valid), 32'd0);
    drain(100, 1'b0);

    // Latency 3, redirect with two requests outstanding.
    lat = 3;
    do_reset();
    repeat (2) @(negedge clock);
    chk("t3_outst_limit", 32'(imem_req_valid), 32'd0);
    redirect(32'h0000_0100, 32'h0000_0100);
    push_exp(32'h0000_0100, 32'h0000_0104);
    push_exp(32'h0000_0104, 32'h0000_0108);
    push_exp(32'h0000_0108, 32'h0000_010C);
    drain(100, 1'b0);

    // Redirect colliding with a response and a decode pop.
    lat = 1;
    do_reset();
    push_exp(32'h0, 32'h4);
    push_exp(32'h4, 32'h8);
    push_exp(32'h8, 32'hC);
    drain(100, 1'b1);
    chk("t4_pre_dec_valid", 32'(dec_valid), 32'd1);
    nc = cyc;
    pop_cyc.delete();
    redirect(32'h0000_0200, 32'h0000_0200);
    chk("t4_flushed", 32'(dec_valid), 32'd0);
    push_exp(32'h0000_0200, 32'h0000_0204);
    push_exp(32'h0000_0204, 32'h0000_0208);
    drain(100, 1'b0);
    chk("t4_redirect_latency", 32'(pop_cyc.size() > 0 ? pop_cyc[0] - nc : -1), 32'd3);

    // Address wrap and misaligned redirect target.
    redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    push_exp(32'hFFFF_FFFC, 32'h0000_0000);
    push_exp(32'h0000_0000, 32'h0000_0004);
    push_exp(32'h0000_0004, 32'h0000_0008);
    drain(100, 1'b0);
    redirect(32'h0000_0103, 32'h0000_0100);
    push_exp(32'h0000_0100, 32'h0000_0104);
    push_exp(32'h0000_0104, 32'h0000_0108);
    drain(100, 1'b0);

    // Back-to-back redirects: the second target wins.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    exp_q.delete();
    exp_req_pc = 32'h0000_0300;
    @(negedge clock);
    redirect_pc = 32'h0000_0400;
    exp_req_pc = 32'h0000_0400;
    @(negedge clock);
    redirect_valid = 1'b0;
    push_exp(32'h0000_0400, 32'h0000_0404);
    push_exp(32'h0000_0404, 32'h0000_0408);
    drain(100, 1'b0);

    // Reset with two FIFO entries and two requests in flight.
    lat = 3;
    do_reset();
    repeat (6) @(negedge clock);
    chk("t6_pre_dec_valid", 32'(dec_valid), 32'd1);
    chk("t6_pre_req_blocked", 32'(imem_req_valid), 32'd0);
    do_reset();
    lat = 1;
    push_exp(32'h0, 32'h4);
    push_exp(32'h4, 32'h8);
    drain(100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

endmodule
